// File: rtl/riscv_ex_pkg.sv
// Shared encodings for the multi-cycle RISC-V execute stage: ALU/memory op codes,
// branch conditions and controller states.
package riscv_ex_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_AND    = 4'd1,
    ALU_OR     = 4'd2,
    ALU_XOR    = 4'd3,
    ALU_SLL    = 4'd4,
    ALU_SRL    = 4'd5,
    ALU_SUB    = 4'd6,
    ALU_BRANCH = 4'd7,
    ALU_SRA    = 4'd8,
    ALU_SLT    = 4'd9,
    ALU_MUL    = 4'd10,
    ALU_MULHU  = 4'd11,
    ALU_DIV    = 4'd12,
    ALU_DIVU   = 4'd13,
    ALU_REM    = 4'd14,
    ALU_REMU   = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10
  } mem_op_e;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_HOLD = 2'd2
  } ex_state_e;

  // Ops 10..15 are the iterative multiply/divide group.
  function automatic logic is_muldiv_op(input logic [3:0] op);
    return (op >= 4'd10);
  endfunction

endpackage

// File: rtl/riscv_muldiv_iter.sv
// Iterative multiply/divide engine: one radix-2 step per cycle for XLEN cycles.
// done is raised combinationally during the last step together with the final result.
module riscv_muldiv_iter
  import riscv_ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] ONE  = {{(XLEN-1){1'b0}}, 1'b1};

  logic            busy;
  logic [CW-1:0]   cnt;
  logic [3:0]      op_q;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] opnd;
  logic [XLEN-1:0] dividend;
  logic            neg_q;
  logic            neg_r;
  logic            div_zero;

  logic            start_is_mul;
  logic            start_signed;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            step_is_mul;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] acc_n;
  logic [XLEN-1:0] lo_n;

  assign start_is_mul = (op == ALU_MUL) || (op == ALU_MULHU);
  assign start_signed = (op == ALU_DIV) || (op == ALU_REM);
  assign a_mag = (start_signed && a[XLEN-1]) ? (~a + ONE) : a;
  assign b_mag = (start_signed && b[XLEN-1]) ? (~b + ONE) : b;
  assign step_is_mul = (op_q == ALU_MUL) || (op_q == ALU_MULHU);
  assign done = busy && (cnt == LAST);

  // One step: shift-add for multiply ({acc,lo} is the product), restoring
  // subtract for divide (acc is the partial remainder, lo collects quotient bits).
  always_comb begin
    sum     = '0;
    shifted = '0;
    diff    = '0;
    acc_n   = acc;
    lo_n    = lo;
    if (step_is_mul) begin
      sum   = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
      acc_n = sum[XLEN:1];
      lo_n  = {sum[0], lo[XLEN-1:1]};
    end else begin
      shifted = {acc, lo[XLEN-1]};
      diff    = shifted - {1'b0, opnd};
      if (!diff[XLEN]) begin
        acc_n = diff[XLEN-1:0];
        lo_n  = {lo[XLEN-2:0], 1'b1};
      end else begin
        acc_n = shifted[XLEN-1:0];
        lo_n  = {lo[XLEN-2:0], 1'b0};
      end
    end
  end

  // Final selection and sign fix-up; divide by zero bypasses the magnitude result.
  always_comb begin
    result = '0;
    case (op_q)
      ALU_MUL:   result = lo_n;
      ALU_MULHU: result = acc_n;
      ALU_DIV, ALU_DIVU: begin
        if (div_zero)   result = '1;
        else if (neg_q) result = ~lo_n + ONE;
        else            result = lo_n;
      end
      ALU_REM, ALU_REMU: begin
        if (div_zero)   result = dividend;
        else if (neg_r) result = ~acc_n + ONE;
        else            result = acc_n;
      end
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      busy     <= 1'b0;
      cnt      <= '0;
      op_q     <= 4'd0;
      acc      <= '0;
      lo       <= '0;
      opnd     <= '0;
      dividend <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (start) begin
      busy     <= 1'b1;
      cnt      <= '0;
      op_q     <= op;
      acc      <= '0;
      lo       <= start_is_mul ? b : a_mag;
      opnd     <= start_is_mul ? a : b_mag;
      dividend <= a;
      neg_q    <= (op == ALU_DIV) && (a[XLEN-1] ^ b[XLEN-1]);
      neg_r    <= (op == ALU_REM) && a[XLEN-1];
      div_zero <= (b == '0);
    end else if (busy) begin
      acc  <= acc_n;
      lo   <= lo_n;
      cnt  <= cnt + CW'(1);
      busy <= !done;
    end
  end

endmodule

// File: rtl/riscv_ex_mc.sv
// Multi-cycle execute stage: single-cycle ALU/branch/address ops plus an optional
// iterative mul/div engine, with a valid/ready handshake and a held output register.
module riscv_ex_mc
  import riscv_ex_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit HAS_MULDIV = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rd,
  input  logic [3:0]      in_alu_op,
  input  logic [2:0]      in_funct3,
  input  logic            in_alu_src_imm,
  input  logic [1:0]      in_mem_op,
  input  logic            in_reg_write,
  input  logic [1:0]      in_wb_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_rd,
  output logic [1:0]      out_mem_op,
  output logic            out_reg_write,
  output logic [1:0]      out_wb_sel,
  output logic            out_branch_taken,
  output logic [XLEN-1:0] out_branch_target
);

  localparam int SHW = $clog2(XLEN);

  ex_state_e       state;
  ex_state_e       state_next;
  logic [XLEN-1:0] op_b;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic            br_cond;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            accept;
  logic            is_md;
  logic            md_start;
  logic            md_done;
  logic [XLEN-1:0] md_result;

  assign op_b      = in_alu_src_imm ? in_imm : in_rs2;
  assign shamt     = op_b[SHW-1:0];
  assign in_ready  = (state == S_IDLE) || ((state == S_HOLD) && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign is_md     = HAS_MULDIV && is_muldiv_op(in_alu_op) && (in_mem_op == MEM_NONE);
  assign md_start  = accept && is_md;
  assign br_taken  = (in_alu_op == ALU_BRANCH) && br_cond;
  assign br_target = br_taken ? (in_pc + in_imm) : '0;

  // Single-cycle datapath; any memory op turns the result into rs1 + imm.
  always_comb begin
    alu_res = '0;
    if (in_mem_op != MEM_NONE) begin
      alu_res = in_rs1 + in_imm;
    end else begin
      case (in_alu_op)
        ALU_ADD: alu_res = in_rs1 + op_b;
        ALU_AND: alu_res = in_rs1 & op_b;
        ALU_OR:  alu_res = in_rs1 | op_b;
        ALU_XOR: alu_res = in_rs1 ^ op_b;
        ALU_SLL: alu_res = in_rs1 << shamt;
        ALU_SRL: alu_res = in_rs1 >> shamt;
        ALU_SUB: alu_res = in_rs1 - op_b;
        ALU_SRA: alu_res = $unsigned($signed(in_rs1) >>> shamt);
        ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(in_rs1) < $signed(op_b))};
        default: alu_res = '0;
      endcase
    end
  end

  // Branches always compare the two register operands.
  always_comb begin
    br_cond = 1'b0;
    case (in_funct3)
      F3_BEQ:  br_cond = (in_rs1 == in_rs2);
      F3_BNE:  br_cond = (in_rs1 != in_rs2);
      F3_BLT:  br_cond = ($signed(in_rs1) < $signed(in_rs2));
      F3_BGE:  br_cond = ($signed(in_rs1) >= $signed(in_rs2));
      F3_BLTU: br_cond = (in_rs1 < in_rs2);
      F3_BGEU: br_cond = (in_rs1 >= in_rs2);
      default: br_cond = 1'b0;
    endcase
  end

  generate
    if (HAS_MULDIV) begin : g_muldiv
      riscv_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .kill   (flush),
        .start  (md_start),
        .op     (in_alu_op),
        .a      (in_rs1),
        .b      (op_b),
        .done   (md_done),
        .result (md_result)
      );
    end else begin : g_no_muldiv
      assign md_done   = 1'b0;
      assign md_result = '0;
    end
  endgenerate

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) state_next = is_md ? S_ITER : S_HOLD;
          else        state_next = S_IDLE;
        end
        S_ITER: begin
          if (md_done) state_next = S_HOLD;
          else         state_next = S_ITER;
        end
        S_HOLD: begin
          if (!out_ready)  state_next = S_HOLD;
          else if (accept) state_next = is_md ? S_ITER : S_HOLD;
          else             state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Output register: controls are captured at accept; mul/div results land when done.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid         <= 1'b0;
      out_result        <= '0;
      out_store_data    <= '0;
      out_rd            <= 5'd0;
      out_mem_op        <= 2'b00;
      out_reg_write     <= 1'b0;
      out_wb_sel        <= 2'b00;
      out_branch_taken  <= 1'b0;
      out_branch_target <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid         <= !is_md;
      out_result        <= is_md ? '0 : alu_res;
      out_store_data    <= in_rs2;
      out_rd            <= in_rd;
      out_mem_op        <= in_mem_op;
      out_reg_write     <= in_reg_write;
      out_wb_sel        <= in_wb_sel;
      out_branch_taken  <= br_taken;
      out_branch_target <= br_target;
    end else if ((state == S_ITER) && md_done) begin
      out_valid  <= 1'b1;
      out_result <= md_result;
    end else if ((state == S_HOLD) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_ex_mc.sv
// Self-checking bench for riscv_ex_mc: directed spec vectors, randomized ops against an
// arithmetic reference model, stall/back-to-back throughput, reset and flush behaviour.
module tb_riscv_ex_mc;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_alu_src_imm, in_reg_write;
  logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
  logic [4:0]  in_rd;
  logic [3:0]  in_alu_op;
  logic [2:0]  in_funct3;
  logic [1:0]  in_mem_op, in_wb_sel;
  logic        out_valid, out_ready, out_reg_write, out_branch_taken;
  logic [31:0] out_result, out_store_data, out_branch_target;
  logic [4:0]  out_rd;
  logic [1:0]  out_mem_op, out_wb_sel;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc, rs1, rs2, imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic [2:0]  funct3;
    logic        src_imm;
    logic [1:0]  mem_op;
    logic        reg_write;
    logic [1:0]  wb_sel;
  } op_t;

  typedef struct {
    logic [31:0] result, store_data, target;
    logic [4:0]  rd;
    logic [1:0]  mem_op, wb_sel;
    logic        reg_write, taken;
    int          lat;
  } res_t;

  riscv_ex_mc #(.XLEN(32), .HAS_MULDIV(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
    .in_alu_op(in_alu_op), .in_funct3(in_funct3), .in_alu_src_imm(in_alu_src_imm),
    .in_mem_op(in_mem_op), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_store_data(out_store_data), .out_rd(out_rd), .out_mem_op(out_mem_op),
    .out_reg_write(out_reg_write), .out_wb_sel(out_wb_sel),
    .out_branch_taken(out_branch_taken), .out_branch_target(out_branch_target)
  );

  always #5 clk = ~clk;

  // Reference model: RISC-V semantics expressed with plain integer arithmetic.
  function automatic res_t model(input op_t o);
    res_t e;
    logic [31:0] b;
    logic [63:0] prod;
    int sa, sb, sr2, sh;
    bit cond;
    b    = o.src_imm ? o.imm : o.rs2;
    sh   = int'(b[4:0]);
    sa   = int'(o.rs1);
    sb   = int'(b);
    sr2  = int'(o.rs2);
    prod = 64'(o.rs1) * 64'(b);
    e.result = 32'd0;
    e.lat    = 1;
    if (o.mem_op != 2'b00) begin
      e.result = o.rs1 + o.imm;
    end else begin
      case (o.alu_op)
        4'd0:  e.result = o.rs1 + b;
        4'd1:  e.result = o.rs1 & b;
        4'd2:  e.result = o.rs1 | b;
        4'd3:  e.result = o.rs1 ^ b;
        4'd4:  e.result = o.rs1 << sh;
        4'd5:  e.result = o.rs1 >> sh;
        4'd6:  e.result = o.rs1 - b;
        4'd8:  e.result = 32'(sa >>> sh);
        4'd9:  e.result = (sa < sb) ? 32'd1 : 32'd0;
        4'd10: e.result = prod[31:0];
        4'd11: e.result = prod[63:32];
        4'd12: begin
          if (b == 32'd0) e.result = 32'hFFFFFFFF;
          else if (o.rs1 == 32'h80000000 && b == 32'hFFFFFFFF) e.result = o.rs1;
          else e.result = 32'(sa / sb);
        end
        4'd13: e.result = (b == 32'd0) ? 32'hFFFFFFFF : (o.rs1 / b);
        4'd14: begin
          if (b == 32'd0) e.result = o.rs1;
          else if (o.rs1 == 32'h80000000 && b == 32'hFFFFFFFF) e.result = 32'd0;
          else e.result = 32'(sa % sb);
        end
        4'd15: e.result = (b == 32'd0) ? o.rs1 : (o.rs1 % b);
        default: e.result = 32'd0;
      endcase
      if (o.alu_op >= 4'd10) e.lat = 33;
    end
    case (o.funct3)
      3'b000:  cond = (o.rs1 == o.rs2);
      3'b001:  cond = (o.rs1 != o.rs2);
      3'b100:  cond = (sa < sr2);
      3'b101:  cond = (sa >= sr2);
      3'b110:  cond = (o.rs1 < o.rs2);
      3'b111:  cond = (o.rs1 >= o.rs2);
      default: cond = 1'b0;
    endcase
    e.taken      = (o.alu_op == 4'd7) && cond;
    e.target     = e.taken ? (o.pc + o.imm) : 32'd0;
    e.store_data = o.rs2;
    e.rd         = o.rd;
    e.mem_op     = o.mem_op;
    e.reg_write  = o.reg_write;
    e.wb_sel     = o.wb_sel;
    return e;
  endfunction

  function automatic op_t mk(input logic [3:0] alu, input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [31:0] imm, input logic src, input logic [2:0] f3,
                             input logic [1:0] mem, input logic [31:0] pc);
    op_t o;
    o.alu_op = alu; o.rs1 = rs1; o.rs2 = rs2; o.imm = imm; o.src_imm = src;
    o.funct3 = f3; o.mem_op = mem; o.pc = pc;
    o.rd = 5'd9; o.reg_write = 1'b1; o.wb_sel = 2'd1;
    return o;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.alu_op    = 4'($urandom_range(0, 15));
    o.rs1       = rand_word();
    o.rs2       = rand_word();
    o.imm       = rand_word();
    o.pc        = 32'($urandom) & 32'hFFFFFFFC;
    o.src_imm   = 1'($urandom_range(0, 1));
    o.funct3    = 3'($urandom_range(0, 7));
    o.mem_op    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
    o.rd        = 5'($urandom);
    o.reg_write = 1'($urandom_range(0, 1));
    o.wb_sel    = 2'($urandom);
    return o;
  endfunction

  task automatic drive(input op_t o);
    in_pc = o.pc; in_rs1 = o.rs1; in_rs2 = o.rs2; in_imm = o.imm; in_rd = o.rd;
    in_alu_op = o.alu_op; in_funct3 = o.funct3; in_alu_src_imm = o.src_imm;
    in_mem_op = o.mem_op; in_reg_write = o.reg_write; in_wb_sel = o.wb_sel;
  endtask

  // Issue one op from IDLE, wait (bounded) for the result, capture it, then drain.
  task automatic run_op(input op_t o, output res_t got);
    drive(o);
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    got.lat = 1;
    while (!out_valid && got.lat < 200) begin
      @(posedge clk); #1;
      got.lat++;
    end
    got.result = out_result; got.store_data = out_store_data; got.target = out_branch_target;
    got.rd = out_rd; got.mem_op = out_mem_op; got.wb_sel = out_wb_sel;
    got.reg_write = out_reg_write; got.taken = out_branch_taken;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_result !== 32'd0 || out_rd !== 5'd0 || out_branch_taken !== 1'b0 || out_branch_target !== 32'd0)
      begin failures++; $display("FAIL reset_outputs result=%h rd=%0d taken=%0b target=%h exp all 0", out_result, out_rd, out_branch_taken, out_branch_target); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    op_t dops[14];
    logic [31:0] dres[14];
    int dlat[14];
    logic dtk[14];
    logic [31:0] dtg[14];
    res_t got;
    dops[0]  = mk(4'd0,  32'd5, 32'd0, 32'hFFFFFFFD, 1'b1, 3'b010, 2'b00, 32'h0);
    dres[0] = 32'd2;        dlat[0] = 1;  dtk[0] = 1'b0; dtg[0] = 32'h0;
    dops[1]  = mk(4'd12, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b0, 3'b010, 2'b00, 32'h0);
    dres[1] = 32'hFFFFFFFD; dlat[1] = 33; dtk[1] = 1'b0; dtg[1] = 32'h0;
    dops[2]  = mk(4'd14, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b0, 3'b010, 2'b00, 32'h0);
    dres[2] = 32'hFFFFFFFF; dlat[2] = 33; dtk[2] = 1'b0; dtg[2] = 32'h0;
    dops[3]  = mk(4'd13, 32'h00001234, 32'd0, 32'd0, 1'b0, 3'b010, 2'b00, 32'h0);
    dres[3] = 32'hFFFFFFFF; dlat[3] = 33; dtk[3] = 1'b0; dtg[3] = 32'h0;
    dops[4]  = mk(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 3'b010, 2'b00, 32'h0);
    dres[4] = 32'hFFFFFFFE; dlat[4] = 33; dtk[4] = 1'b0; dtg[4] = 32'h0;
    dops[5]  = mk(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 3'b010, 2'b00, 32'h0);
    dres[5] = 32'h00000001; dlat[5] = 33; dtk[5] = 1'b0; dtg[5] = 32'h0;
    dops[6]  = mk(4'd7,  32'd1, 32'hFFFFFFFF, 32'h20, 1'b0, 3'b110, 2'b00, 32'h100);
    dres[6] = 32'd0;        dlat[6] = 1;  dtk[6] = 1'b1; dtg[6] = 32'h120;
    dops[7]  = mk(4'd7,  32'd1, 32'hFFFFFFFF, 32'h20, 1'b0, 3'b100, 2'b00, 32'h100);
    dres[7] = 32'd0;        dlat[7] = 1;  dtk[7] = 1'b0; dtg[7] = 32'h0;
    dops[8]  = mk(4'd12, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 3'b010, 2'b00, 32'h0);
    dres[8] = 32'h80000000; dlat[8] = 33; dtk[8] = 1'b0; dtg[8] = 32'h0;
    dops[9]  = mk(4'd14, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 3'b010, 2'b00, 32'h0);
    dres[9] = 32'd0;        dlat[9] = 33; dtk[9] = 1'b0; dtg[9] = 32'h0;
    dops[10] = mk(4'd12, 32'hFFFFFFFB, 32'd0, 32'd0, 1'b0, 3'b010, 2'b00, 32'h0);
    dres[10] = 32'hFFFFFFFF; dlat[10] = 33; dtk[10] = 1'b0; dtg[10] = 32'h0;
    dops[11] = mk(4'd14, 32'hFFFFFFFB, 32'd0, 32'd0, 1'b0, 3'b010, 2'b00, 32'h0);
    dres[11] = 32'hFFFFFFFB; dlat[11] = 33; dtk[11] = 1'b0; dtg[11] = 32'h0;
    dops[12] = mk(4'd10, 32'h00001000, 32'd7, 32'h10, 1'b0, 3'b010, 2'b01, 32'h0);
    dres[12] = 32'h00001010; dlat[12] = 1;  dtk[12] = 1'b0; dtg[12] = 32'h0;
    dops[13] = mk(4'd8,  32'h80000000, 32'h24, 32'd0, 1'b0, 3'b010, 2'b00, 32'h0);
    dres[13] = 32'hF8000000; dlat[13] = 1;  dtk[13] = 1'b0; dtg[13] = 32'h0;
    for (int i = 0; i < 14; i++) begin
      run_op(dops[i], got);
      checks++; if (got.result !== dres[i]) begin failures++; $display("FAIL directed_result[%0d] got=%h exp=%h", i, got.result, dres[i]); end
      checks++; if (got.lat != dlat[i]) begin failures++; $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, got.lat, dlat[i]); end
      checks++; if (got.taken !== dtk[i] || got.target !== dtg[i])
        begin failures++; $display("FAIL directed_branch[%0d] got=%0b/%h exp=%0b/%h", i, got.taken, got.target, dtk[i], dtg[i]); end
    end
  endtask

  task automatic test_random();
    op_t o;
    res_t e, got;
    for (int n = 0; n < 150; n++) begin
      o = rand_op();
      e = model(o);
      run_op(o, got);
      checks++; if (got.result !== e.result) begin failures++; $display("FAIL rand_result[%0d] op=%0d got=%h exp=%h", n, o.alu_op, got.result, e.result); end
      checks++; if (got.lat != e.lat) begin failures++; $display("FAIL rand_latency[%0d] op=%0d got=%0d exp=%0d", n, o.alu_op, got.lat, e.lat); end
      checks++; if (got.taken !== e.taken || got.target !== e.target)
        begin failures++; $display("FAIL rand_branch[%0d] got=%0b/%h exp=%0b/%h", n, got.taken, got.target, e.taken, e.target); end
      checks++; if (got.store_data !== e.store_data || got.rd !== e.rd || got.mem_op !== e.mem_op ||
                    got.reg_write !== e.reg_write || got.wb_sel !== e.wb_sel)
        begin failures++; $display("FAIL rand_controls[%0d] sd=%h rd=%0d mem=%0d rw=%0b wb=%0d exp sd=%h rd=%0d mem=%0d rw=%0b wb=%0d",
                                   n, got.store_data, got.rd, got.mem_op, got.reg_write, got.wb_sel,
                                   e.store_data, e.rd, e.mem_op, e.reg_write, e.wb_sel); end
    end
  endtask

  task automatic test_back_to_back();
    op_t oa, ob, o;
    res_t ea, eb, e;
    oa = mk(4'd0, rand_word(), rand_word(), 32'd0, 1'b0, 3'b010, 2'b00, 32'h0);
    oa.rd = 5'd17;
    ob = mk(4'd0, rand_word(), rand_word(), 32'd0, 1'b0, 3'b010, 2'b00, 32'h0);
    ea = model(oa); eb = model(ob);
    drive(oa); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    drive(ob);
    for (int i = 0; i < 6; i++) begin
      checks++; if (out_valid !== 1'b1 || out_result !== ea.result || out_rd !== 5'd17)
        begin failures++; $display("FAIL stall_stable[%0d] valid=%0b result=%h rd=%0d exp 1/%h/17", i, out_valid, out_result, out_rd, ea.result); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d] got=%0b exp=0", i, in_ready); end
      if (i < 5) begin @(posedge clk); #1; end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%0b exp=1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_result !== eb.result)
      begin failures++; $display("FAIL release_next_op valid=%0b result=%h exp 1/%h", out_valid, out_result, eb.result); end
    for (int k = 0; k < 10; k++) begin
      o = mk(4'd0, rand_word(), rand_word(), 32'd0, 1'b0, 3'b010, 2'b00, 32'h0);
      e = model(o);
      drive(o);
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_result !== e.result)
        begin failures++; $display("FAIL b2b[%0d] valid=%0b result=%h exp 1/%h", k, out_valid, out_result, e.result); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_rst_mid_div();
    op_t o;
    res_t e, got;
    o = mk(4'd12, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b0, 3'b010, 2'b00, 32'h0);
    drive(o); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL iter_out_valid[%0d] got=%0b exp=0", i, out_valid); end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin failures++; $display("FAIL rst_mid_div valid=%0b ready=%0b exp 0/1", out_valid, in_ready); end
    checks++; if (out_result !== 32'd0 || out_rd !== 5'd0)
      begin failures++; $display("FAIL rst_mid_div_clear result=%h rd=%0d exp 0/0", out_result, out_rd); end
    repeat (30) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_discard got=%0b exp=0", out_valid); end
    o = mk(4'd13, 32'd100, 32'd7, 32'd0, 1'b0, 3'b010, 2'b00, 32'h0);
    e = model(o);
    run_op(o, got);
    checks++; if (got.result !== e.result || got.lat != e.lat)
      begin failures++; $display("FAIL after_rst_div result=%h lat=%0d exp %h/%0d", got.result, got.lat, e.result, e.lat); end
  endtask

  task automatic test_flush();
    op_t o;
    res_t e, got;
    int seen;
    o = mk(4'd0, 32'd5, 32'd3, 32'd0, 1'b0, 3'b010, 2'b00, 32'h0);
    drive(o); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd8)
      begin failures++; $display("FAIL flush_setup valid=%0b result=%h exp 1/8", out_valid, out_result); end
    drive(mk(4'd1, 32'hFF, 32'h0F, 32'd0, 1'b0, 3'b010, 2'b00, 32'h0));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin failures++; $display("FAIL flush_hold valid=%0b ready=%0b exp 0/1", out_valid, in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_drop got=%0b exp=0", out_valid); end
    drive(mk(4'd10, 32'd1234, 32'd5678, 32'd0, 1'b0, 3'b010, 2'b00, 32'h0));
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL flush_iter valid_cycles=%0d exp=0", seen); end
    o = mk(4'd11, rand_word(), rand_word(), 32'd0, 1'b0, 3'b010, 2'b00, 32'h0);
    e = model(o);
    run_op(o, got);
    checks++; if (got.result !== e.result || got.lat != e.lat)
      begin failures++; $display("FAIL after_flush_mulhu result=%h lat=%0d exp %h/%0d", got.result, got.lat, e.result, e.lat); end
    o = mk(4'd0, 32'd5, 32'd3, 32'd0, 1'b0, 3'b010, 2'b00, 32'h0);
    drive(o); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_result !== 32'd0 || out_rd !== 5'd0)
      begin failures++; $display("FAIL rst_over_flush valid=%0b result=%h rd=%0d exp 0/0/0", out_valid, out_result, out_rd); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(mk(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'b010, 2'b00, 32'h0));
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_rst_mid_div();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
